// File: rtl/frame_packer_if.sv
// Stream bundle for frame_packer: show-ahead buffer pop side plus framed valid/ready output.
// master = packer view, slave = buffer/sink view.
interface frame_packer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_rd_en;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sof;
  logic                  out_eof;

  modport master (
    input  in_data, in_valid, out_ready,
    output in_rd_en, out_data, out_valid, out_sof, out_eof
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  in_rd_en, out_data, out_valid, out_sof, out_eof
  );
endinterface

// File: rtl/frame_packer.sv
// Packs show-ahead buffer words into header + FRAME_LEN payload frames on a valid/ready stream.
// Define FRAME_PACKER_CHECKSUM_EN to append a payload-sum trailer word to every frame.
module frame_packer #(
  parameter int             DATA_WIDTH = 32,
  parameter int             FRAME_LEN  = 4,
  parameter logic [7:0]     SYNC_BYTE  = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  frame_packer_if.master bus,
  output logic [7:0]    frame_seq,
  output logic          busy
);
  localparam logic [15:0] LEN16 = 16'(FRAME_LEN);
  localparam logic [15:0] LAST  = 16'(FRAME_LEN - 1);

`ifdef FRAME_PACKER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;
  logic [DATA_WIDTH-1:0] r_acc;
`else
  typedef enum logic [0:0] {IDLE, PAYLOAD} state_t;
`endif

  state_t                r_state;
  logic [15:0]           r_cnt;
  logic [7:0]            r_seq;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_sof;
  logic                  r_eof;

  logic                  w_load;
  logic                  w_pop;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_header;

  // Output register may advance when empty or when the sink takes the current word.
  assign w_load   = !r_valid || bus.out_ready;
  assign w_pop    = (r_state == PAYLOAD) && bus.in_valid && w_load;
  assign w_last   = (r_cnt == LAST);
  assign w_header = DATA_WIDTH'({SYNC_BYTE, r_seq, LEN16});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_seq   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
`ifdef FRAME_PACKER_CHECKSUM_EN
      r_acc   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            if (bus.in_valid) begin
              r_data  <= w_header;
              r_valid <= 1'b1;
              r_sof   <= 1'b1;
              r_eof   <= 1'b0;
              r_state <= PAYLOAD;
            end else begin
              r_valid <= 1'b0;
            end
          end
        end
        PAYLOAD: begin
          if (w_pop) begin
            r_data  <= bus.in_data;
            r_valid <= 1'b1;
            r_sof   <= 1'b0;
            r_cnt   <= r_cnt + 16'd1;
`ifdef FRAME_PACKER_CHECKSUM_EN
            r_acc   <= r_acc + bus.in_data;
`endif
            if (w_last) begin
              r_cnt   <= '0;
`ifdef FRAME_PACKER_CHECKSUM_EN
              r_eof   <= 1'b0;
              r_state <= TRAILER;
`else
              r_eof   <= 1'b1;
              r_seq   <= r_seq + 8'd1;
              r_state <= IDLE;
`endif
            end else begin
              r_eof   <= 1'b0;
            end
          end else if (w_load) begin
            // Buffer ran dry: emit a bubble rather than a filler word.
            r_valid <= 1'b0;
          end
        end
`ifdef FRAME_PACKER_CHECKSUM_EN
        TRAILER: begin
          if (w_load) begin
            r_data  <= r_acc;
            r_valid <= 1'b1;
            r_sof   <= 1'b0;
            r_eof   <= 1'b1;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_seq   <= r_seq + 8'd1;
            r_state <= IDLE;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_rd_en  = w_pop;
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.out_sof   = r_sof;
  assign bus.out_eof   = r_eof;
  assign frame_seq     = r_seq;
  assign busy          = (r_state != IDLE);
endmodule
